// File: rtl/legv8_pkg.sv
// Shared types and defaults for the LEGv8 fetch front end.
package legv8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam int          DEF_WIDTH    = 32;
    localparam int          DEF_PC_INC   = 1;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_incrementer.sv
// Constant-increment PC adder; wraps modulo 2^WIDTH with no carry out.
module pc_incrementer #(
    parameter int WIDTH  = 32,
    parameter int PC_INC = 1
) (
    input  logic [WIDTH-1:0] i_pc,
    output logic [WIDTH-1:0] o_pc_plus_inc
);

    assign o_pc_plus_inc = i_pc + WIDTH'(PC_INC);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register and fetch FSM: picks sequential / branch / hold each cycle and
// drives a registered-only imem req; halt > branch > stall > handshake.
module pc_fetch_sequencer
    import legv8_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               PC_INC   = DEF_PC_INC,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             fetch_fire,
    output logic             squash,
    output logic             halted,
    output logic [31:0]      fetch_count
);

    fetch_state_t     r_state;
    fetch_state_t     w_nxt_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_nxt_pc;
    logic [WIDTH-1:0] w_pc_plus_inc;
    logic [31:0]      r_fetch_count;
    logic             r_fetch_fire;
    logic             r_squash;
    logic             w_fire;
    logic             w_redirect;

    pc_incrementer #(
        .WIDTH  (WIDTH),
        .PC_INC (PC_INC)
    ) u_pc_inc (
        .i_pc          (r_pc),
        .o_pc_plus_inc (w_pc_plus_inc)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_fire      = 1'b0;
        w_redirect  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (halt_req) begin
                    w_nxt_state = ST_HALT;
                end else begin
                    // Branch in IDLE only preloads the PC; nothing is in flight to squash.
                    if (branch_valid) w_nxt_pc = branch_target;
                    if (start)        w_nxt_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (halt_req) begin
                    w_nxt_state = ST_HALT;
                end else if (branch_valid) begin
                    w_nxt_pc   = branch_target;
                    w_redirect = 1'b1;
                end else if (stall) begin
                    w_nxt_state = ST_HOLD;
                end else if (imem_ready) begin
                    w_nxt_pc = w_pc_plus_inc;
                    w_fire   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (halt_req) begin
                    w_nxt_state = ST_HALT;
                end else if (branch_valid) begin
                    w_nxt_pc    = branch_target;
                    w_redirect  = 1'b1;
                    w_nxt_state = ST_FETCH;
                end else if (!stall) begin
                    w_nxt_state = ST_FETCH;
                end
            end
            default: begin
                w_nxt_state = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'd0;
            r_fetch_fire  <= 1'b0;
            r_squash      <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_pc         <= w_nxt_pc;
            r_fetch_fire <= w_fire;
            r_squash     <= w_redirect;
            if (w_fire) r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus_inc = w_pc_plus_inc;
    assign fetch_fire  = r_fetch_fire;
    assign squash      = r_squash;
    assign halted      = (r_state == ST_HALT);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: per-cycle expectations from a spec model.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stall, halt_req, branch_valid, imem_ready;
    logic [31:0] branch_target;
    logic        imem_req, fetch_fire, squash, halted;
    logic [31:0] imem_addr, pc, pc_plus_inc, fetch_count;

    pc_fetch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .halt_req      (halt_req),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .pc_plus_inc   (pc_plus_inc),
        .fetch_fire    (fetch_fire),
        .squash        (squash),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  flg;   // {imem_req, fetch_fire, squash, halted}
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [3:0]  flg;
        logic [31:0] cnt;
    } obs_t;

    exp_t sb_exp[$];
    obs_t sb_obs[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: 0 IDLE, 1 FETCH, 2 HOLD, 3 HALT
    int          m_st;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic cyc(input logic st, input logic stl, input logic hr, input logic bv,
                       input logic [31:0] bt, input logic rdy);
        logic ff, sq;
        obs_t o;
        start = st; stall = stl; halt_req = hr; branch_valid = bv;
        branch_target = bt; imem_ready = rdy;
        ff = 1'b0; sq = 1'b0;
        case (m_st)
            0: begin
                if (hr) m_st = 3;
                else begin
                    if (bv) m_pc = bt;
                    if (st) m_st = 1;
                end
            end
            1: begin
                if (hr) m_st = 3;
                else if (bv) begin m_pc = bt; sq = 1'b1; end
                else if (stl) m_st = 2;
                else if (rdy) begin m_pc = m_pc + 32'd1; m_cnt = m_cnt + 32'd1; ff = 1'b1; end
            end
            2: begin
                if (hr) m_st = 3;
                else if (bv) begin m_pc = bt; sq = 1'b1; m_st = 1; end
                else if (!stl) m_st = 1;
            end
            default: ;
        endcase
        sb_exp.push_back('{m_pc, {(m_st == 1), ff, sq, (m_st == 3)}, m_cnt});
        @(negedge clk);
        o.pc = pc; o.addr = imem_addr; o.cnt = fetch_count;
        o.flg = {imem_req, fetch_fire, squash, halted};
        sb_obs.push_back(o);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        start = 0; stall = 0; halt_req = 0; branch_valid = 0; imem_ready = 0;
        branch_target = 32'h0;
        m_st = 0; m_pc = 32'h0; m_cnt = 32'h0;
        sb_exp.delete(); sb_obs.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1; stall = 0; halt_req = 0; branch_valid = 1; imem_ready = 1;
        branch_target = 32'h55;
        @(negedge clk);
        n_chk++;
        if (pc !== 32'h0 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc pc=%h addr=%h required 0", pc, imem_addr);
        end
        n_chk++;
        if ({imem_req, fetch_fire, squash, halted} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b required 0000", {imem_req, fetch_fire, squash, halted});
        end
        n_chk++;
        if (fetch_count !== 32'h0 || pc_plus_inc !== 32'h1) begin
            n_fail++; $display("FAIL reset_cnt cnt=%h ppi=%h required 0/1", fetch_count, pc_plus_inc);
        end
    endtask

    task automatic drain(input string nm);
        exp_t e;
        obs_t o;
        while (sb_exp.size() > 0 && sb_obs.size() > 0) begin
            e = sb_exp.pop_front();
            o = sb_obs.pop_front();
            n_chk++;
            if (o.pc !== e.pc || o.addr !== e.pc) begin
                n_fail++; $display("FAIL %s_pc pc=%h addr=%h required %h", nm, o.pc, o.addr, e.pc);
            end
            n_chk++;
            if (o.flg !== e.flg) begin
                n_fail++; $display("FAIL %s_flags req/ff/sq/halt=%b required %b", nm, o.flg, e.flg);
            end
            n_chk++;
            if (o.cnt !== e.cnt) begin
                n_fail++; $display("FAIL %s_count got %0d required %0d", nm, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_sequential();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
        drain("seq");
        n_chk++;
        if (pc !== 32'd4 || fetch_count !== 32'd4 || fetch_fire !== 1'b1) begin
            n_fail++; $display("FAIL seq_final pc=%h cnt=%0d ff=%b required 4/4/1", pc, fetch_count, fetch_fire);
        end
    endtask

    task automatic test_ready_low();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        drain("rdy_low");
        n_chk++;
        if (pc !== 32'd1 || fetch_count !== 32'd1) begin
            n_fail++; $display("FAIL rdy_low_final pc=%h cnt=%0d required 1/1", pc, fetch_count);
        end
    endtask

    task automatic test_branch();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 32'h40, 1);
        n_chk++;
        if (pc !== 32'h40 || squash !== 1'b1 || fetch_fire !== 1'b0 || fetch_count !== 32'd5) begin
            n_fail++; $display("FAIL branch_redirect pc=%h sq=%b ff=%b cnt=%0d required 40/1/0/5",
                               pc, squash, fetch_fire, fetch_count);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h80, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 32'hC0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        drain("branch");
    endtask

    task automatic test_stall();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        n_chk++;
        if (imem_req !== 1'b0 || pc !== 32'd3) begin
            n_fail++; $display("FAIL stall_hold req=%b pc=%h required 0/3", imem_req, pc);
        end
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        drain("stall");
        n_chk++;
        if (pc !== 32'd4) begin
            n_fail++; $display("FAIL stall_resume pc=%h required 4", pc);
        end
    endtask

    task automatic test_halt();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 32'h77, 1);
        cyc(1, 0, 0, 1, 32'h99, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        drain("halt");
        n_chk++;
        if (halted !== 1'b1 || pc !== 32'd2 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL halt_state halted=%b pc=%h req=%b required 1/2/0", halted, pc, imem_req);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (pc !== 32'h0 || halted !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset pc=%h halted=%b req=%b required 0/0/0", pc, halted, imem_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        reset_dut();
        cyc(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        n_chk++;
        if (pc !== 32'hFFFF_FFFF || imem_req !== 1'b0 || squash !== 1'b0) begin
            n_fail++; $display("FAIL preload pc=%h req=%b sq=%b required ffffffff/0/0", pc, imem_req, squash);
        end
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        drain("wrap");
        n_chk++;
        if (pc !== 32'h0 || pc_plus_inc !== 32'h1) begin
            n_fail++; $display("FAIL wrap pc=%h ppi=%h required 0/1", pc, pc_plus_inc);
        end
    endtask

    task automatic test_midfetch_reset();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        drain("mid_pre");
        imem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (imem_req !== 1'b0 || fetch_fire !== 1'b0 || pc !== 32'h0) begin
            n_fail++; $display("FAIL midreset_now req=%b ff=%b pc=%h required 0/0/0", imem_req, fetch_fire, pc);
        end
        @(negedge clk);
        n_chk++;
        if (fetch_fire !== 1'b0 || fetch_count !== 32'h0 || pc !== 32'h0) begin
            n_fail++; $display("FAIL midreset_after ff=%b cnt=%0d pc=%h required 0/0/0", fetch_fire, fetch_count, pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 80; i++)
            cyc(0, ($urandom_range(0, 3) == 0), 1'b0, ($urandom_range(0, 5) == 0),
                $urandom, ($urandom_range(0, 2) != 0));
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        drain("b2b");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_low();
        test_branch();
        test_stall();
        test_halt();
        test_wrap();
        test_midfetch_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the LEGv8 core.
- Each cycle it selects the next PC from three sources: PC + PC_INC (word-addressed sequential flow), a branch target, or hold.
- Presents addresses to instruction memory over a req/ready handshake.
- Sits between the branch/decode logic and instruction memory; stall and halt come from the hazard and control units.

Parameters:
- WIDTH, 32, PC and address width in bits.
- PC_INC, 1, sequential increment (word addressing).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE and begin fetching.
- stall  input  1  hazard stall; freeze PC and drop request.
- halt_req  input  1  stop fetching until reset.
- branch_valid  input  1  redirect this cycle.
- branch_target  input  WIDTH  redirect address.
- imem_ready  input  1  instruction memory accepts the current request.
- imem_req  output  1  fetch request valid.
- imem_addr  output  WIDTH  fetch address; always equals pc.
- pc  output  WIDTH  current PC register.
- pc_plus_inc  output  WIDTH  pc + PC_INC, forwarded for branch-and-link.
- fetch_fire  output  1  registered one-cycle pulse: a fetch was accepted last cycle.
- squash  output  1  registered one-cycle pulse: a redirect occurred; the downstream instruction register must discard.
- halted  output  1  high in the HALT state.
- fetch_count  output  32  number of accepted fetches; wraps modulo 2^32.

Behaviour:
- Reset (async, rst_n low):
  - pc = RESET_PC, state = IDLE, fetch_count = 0.
  - imem_req, fetch_fire, squash and halted = 0.
  - Reset asserted mid-fetch abandons the request immediately; no pulse is generated.
- States: IDLE, FETCH, HOLD, HALT.
  - IDLE: imem_req = 0. start -> FETCH. branch_valid in IDLE loads pc = branch_target and stays in IDLE (preload).
  - FETCH: imem_req = 1.
    - Handshake fires when imem_req & imem_ready.
    - On fire: pc <= pc + PC_INC; fetch_count++; fetch_fire = 1 next cycle.
  - HOLD: imem_req = 0, pc held. stall low -> FETCH.
  - HALT: imem_req = 0, halted = 1. Terminal until reset; all other inputs are ignored.
- Priority when events coincide in FETCH/HOLD (highest first): halt_req > branch_valid > stall > handshake.
  - halt_req -> HALT. pc is not updated, even if imem_ready is high.
  - branch_valid:
    - pc <= branch_target, next state FETCH (even if stall is high; a stall re-asserted next cycle moves to HOLD).
    - squash = 1 next cycle.
    - A handshake in the same cycle is squashed: no fetch_fire, no count increment.
  - stall in FETCH -> HOLD. A same-cycle imem_ready is ignored: no fire, pc held.
- imem_req and imem_addr are driven from state and pc registers only. There is no combinational path from imem_ready to imem_req.
- Latency:
  - A fire at edge N makes imem_addr = old pc + PC_INC visible after edge N.
  - A back-to-back fire every cycle is supported (throughput of 1 fetch per cycle).
- Arithmetic:
  - pc + PC_INC is unsigned modulo 2^WIDTH; 0xFFFFFFFF + 1 = 0x00000000 with no flag.
  - branch_target is used verbatim, with no alignment check.
- fetch_fire and squash are never high in the same cycle.

Decomposition:
- Shared package (legv8_pkg): state enum (IDLE=0, FETCH=1, HOLD=2, HALT=3), WIDTH default, RESET_PC default.
- One sub-module: pc_incrementer (WIDTH-bit adder with a constant PC_INC operand), producing pc_plus_inc.
- The FSM and PC register live in the top-level module.

Test Plan:
- Reset then start, imem_ready held high for 4 cycles -> imem_addr 0,1,2,3,4; fetch_fire high for 4 cycles; fetch_count = 4.
- imem_ready low for 3 cycles in FETCH -> imem_req stays 1, pc held at 0, fetch_count unchanged; ready rises -> pc = 1 next cycle.
- pc = 5, branch_valid with target 0x40 and imem_ready high in the same cycle -> pc = 0x40, squash pulse, no fetch_fire, fetch_count unchanged.
- stall for 2 cycles at pc = 3, imem_ready high -> HOLD, imem_req = 0, pc = 3; stall drops -> FETCH, next fire gives pc = 4.
- halt_req together with branch_valid and imem_ready -> HALT, halted = 1, pc unchanged; later start/branch inputs ignored; rst_n low restores pc = 0, IDLE.
- Preload pc = 0xFFFFFFFF via branch in IDLE, start, one fire -> pc = 0x00000000, pc_plus_inc = 0x00000001.
